if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Sequencing controller for the IF stage.
- Owns the PC register.
- Issues one-outstanding-request fetches to instruction memory over a req/gnt + valid handshake.
- Applies ID jump and EX branch redirects, discarding stale responses.
- Buffers a response returned during a pipeline stall.
- Presents a registered PC/instruction/valid triple to ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on IF_Instruction when no valid instruction is present (addi x0,x0,0).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address
- imem_gnt  in  1  memory accepted request this cycle (sampled with imem_req=1)
- instr_valid  in  1  response valid
- instr  in  32  response data
- PC_Stall  in  1  ID not accepting; hold IF outputs
- ID_Jump  in  1  jump redirect from ID
- ID_PC_dest  in  32  jump target
- EX_PC_Branch  in  1  taken-branch redirect from EX
- EX_PC_Branch_dest  in  32  branch target
- IF_PC  out  32  PC of IF_Instruction
- IF_Instruction  out  32  fetched instruction
- IF_Valid  out  1  IF_PC/IF_Instruction valid

Behaviour:
- Reset (Reset_n=0, async):
  - state=IDLE, fetch_pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - IF_PC=RESET_PC, IF_Instruction=NOP_INSTR, IF_Valid=0.
  - skid empty, drop flag clear.
- FSM states:
  - IDLE: one cycle after reset release, no request; go to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_gnt: go to WAIT.
    - Stay in REQ while imem_gnt=0.
    - Do not enter REQ while skid is full.
  - WAIT: imem_req=0, awaiting instr_valid. On instr_valid:
    - if drop flag set: discard the response, clear drop flag, go to REQ;
    - else: deliver (see below), fetch_pc += 4, go to REQ (or HOLD if skid is now full).
  - HOLD: skid full; imem_req=0; go to REQ when skid drains.
- Delivery:
  - If PC_Stall=0: the next edge loads IF_PC, IF_Instruction, IF_Valid=1.
  - If PC_Stall=1: the response goes to the 1-entry skid (pc + instr).
- Output update when PC_Stall=0:
  - Skid entry has priority over a new response.
  - With no source available: IF_Valid=0, IF_Instruction=NOP_INSTR.
- Output hold: PC_Stall=1 holds IF_PC, IF_Instruction and IF_Valid unchanged.
- Redirect:
  - Target: EX_PC_Branch takes priority over ID_Jump; target = EX_PC_Branch_dest, else ID_PC_dest.
  - Takes effect regardless of PC_Stall. Next edge:
    - fetch_pc=target;
    - skid cleared;
    - IF_Valid=0, IF_Instruction=NOP_INSTR.
  - By state at redirect:
    - REQ (not granted this cycle): the address switches to target the next cycle; an ungranted request may change address.
    - REQ with gnt, or WAIT with no instr_valid: set drop flag; the pending response is discarded.
    - WAIT with instr_valid in the same cycle: the response is discarded, no drop flag; go to REQ.
    - HOLD: go to REQ.
- Address width: target[1:0] ignored and imem_addr[1:0] forced 0. fetch_pc+4 wraps modulo 2^32.
- Latency: with zero-wait memory (gnt in the REQ cycle, instr_valid the next cycle), IF_Valid is first asserted 3 cycles after reset release. Throughput is one instruction per 2 cycles.

Optional Feature:
Macro IF_FETCH_PERF_EN.
- Defined: adds output ports:
  - fetch_count (32): increments on each delivered (non-dropped) response;
  - flush_count (32): increments on each redirect cycle.
  - Both reset to 0 and wrap.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset release, zero-wait memory returning instr=addr^32'hA5 → imem_addr sequence 0,4,8; IF_Valid first high 3 cycles after release with IF_PC=0, IF_Instruction=32'h0000_00A5.
- imem_gnt held low 4 cycles in REQ → imem_req stays 1, imem_addr stable at 4, no output change, no PC advance.
- PC_Stall=1 for 5 cycles while the response for PC 8 arrives → outputs frozen at PC 4; skid holds PC 8; imem_req=0. Stall release → IF_PC=8 next edge, then fetch of 12.
- ID_Jump with ID_PC_dest=32'h100 in WAIT → late response discarded; next imem_addr=32'h100; IF_Valid=0 until PC 0x100 delivered.
- ID_Jump (dest 0x100) and EX_PC_Branch (dest 0x200) in the same cycle → next imem_addr=32'h200.
- Reset_n asserted mid-WAIT → outputs immediately RESET_PC/NOP_INSTR/IF_Valid=0; a post-reset stray instr_valid is ignored in IDLE.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, runs one-outstanding imem fetches, applies redirects and
// buffers a stalled response in a 1-entry skid. Define IF_FETCH_PERF_EN to add fetch/flush counters.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        PC_Stall,
    input  logic        ID_Jump,
    input  logic [31:0] ID_PC_dest,
    input  logic        EX_PC_Branch,
    input  logic [31:0] EX_PC_Branch_dest,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count,
`endif
    output logic        IF_Valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic        r_drop;
    logic        r_imem_req;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_deliver;
    logic        w_next_drop;
    logic [31:0] w_next_pc;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_instr_nxt;
    logic        w_if_valid_nxt;

    assign w_redirect = ID_Jump | EX_PC_Branch;
    assign w_target   = align_word(EX_PC_Branch ? EX_PC_Branch_dest : ID_PC_dest);

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_fetch_pc;
    assign IF_PC          = r_if_pc;
    assign IF_Instruction = r_if_instr;
    assign IF_Valid       = r_if_valid;

    // Response acceptance, drop-flag tracking and next fetch PC.
    always_comb begin
        w_deliver   = 1'b0;
        w_next_drop = r_drop;
        case (r_state)
            ST_REQ: begin
                if (imem_gnt && w_redirect) begin
                    w_next_drop = 1'b1;
                end else begin
                    w_next_drop = r_drop;
                end
            end
            ST_WAIT: begin
                if (instr_valid) begin
                    w_next_drop = 1'b0;
                    if (!r_drop && !w_redirect) begin
                        w_deliver = 1'b1;
                    end else begin
                        w_deliver = 1'b0;
                    end
                end else if (w_redirect) begin
                    w_next_drop = 1'b1;
                end else begin
                    w_next_drop = r_drop;
                end
            end
            default: begin
                w_next_drop = r_drop;
            end
        endcase
        if (w_redirect) begin
            w_next_pc = w_target;
        end else if (w_deliver) begin
            w_next_pc = r_fetch_pc + 32'd4;
        end else begin
            w_next_pc = r_fetch_pc;
        end
    end

    // Skid buffer and ID-facing output selection; a skidded entry is older, so it goes first.
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_if_pc_nxt      = r_if_pc;
        w_if_instr_nxt   = r_if_instr;
        w_if_valid_nxt   = r_if_valid;
        if (w_redirect) begin
            w_skid_valid_nxt = 1'b0;
            w_if_valid_nxt   = 1'b0;
            w_if_instr_nxt   = NOP_INSTR;
        end else if (PC_Stall) begin
            if (w_deliver) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_pc_nxt    = r_fetch_pc;
                w_skid_instr_nxt = instr;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end else if (r_skid_valid) begin
            w_if_valid_nxt   = 1'b1;
            w_if_pc_nxt      = r_skid_pc;
            w_if_instr_nxt   = r_skid_instr;
            w_skid_valid_nxt = w_deliver;
            w_skid_pc_nxt    = r_fetch_pc;
            w_skid_instr_nxt = instr;
        end else if (w_deliver) begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_fetch_pc;
            w_if_instr_nxt = instr;
        end else begin
            w_if_valid_nxt = 1'b0;
            w_if_instr_nxt = NOP_INSTR;
        end
    end

    // Fetch FSM next state; a full skid parks the FSM in HOLD so no new request is issued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (instr_valid) begin
                    w_next_state = w_skid_valid_nxt ? ST_HOLD : ST_REQ;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_HOLD: begin
                w_next_state = w_skid_valid_nxt ? ST_HOLD : ST_REQ;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC, drop flag and request strobe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= align_word(RESET_PC);
            r_drop     <= 1'b0;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_fetch_pc <= w_next_pc;
            r_drop     <= w_next_drop;
            r_imem_req <= (w_next_state == ST_REQ);
        end
    end

    // Skid entry and registered PC/instruction/valid toward ID.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= 32'h0000_0000;
            r_if_pc      <= RESET_PC;
            r_if_instr   <= NOP_INSTR;
            r_if_valid   <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_valid   <= w_if_valid_nxt;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_flush_count;

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;

    // Free-running wrap-around counters of delivered responses and redirect cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fetch_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            r_fetch_count <= r_fetch_count + {31'd0, w_deliver};
            r_flush_count <= r_flush_count + {31'd0, w_redirect};
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: scripted scenarios followed by randomized memory/stall/redirect
// traffic, all checked every cycle against a transaction-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        PC_Stall = 1'b0;
    logic        ID_Jump = 1'b0;
    logic [31:0] ID_PC_dest = 32'd0;
    logic        EX_PC_Branch = 1'b0;
    logic [31:0] EX_PC_Branch_dest = 32'd0;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;

    if_fetch_ctrl dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .PC_Stall          (PC_Stall),
        .ID_Jump           (ID_Jump),
        .ID_PC_dest        (ID_PC_dest),
        .EX_PC_Branch      (EX_PC_Branch),
        .EX_PC_Branch_dest (EX_PC_Branch_dest),
        .IF_PC             (IF_PC),
        .IF_Instruction    (IF_Instruction),
        .IF_Valid          (IF_Valid)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus knobs
    int          p_gnt = 100, min_dly = 0, max_dly = 0, p_stall = 0, p_redir = 0, p_stray = 0;
    logic        f_stall = 1'b0, f_jump = 1'b0, f_br = 1'b0;
    logic [31:0] f_jdest = 32'd0, f_bdest = 32'd0;

    // memory model
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_dly = 0;
    logic [31:0] gaddr_q[$];

    // reference model: PC, request/outstanding bookkeeping, buffered responses, ID-facing view
    logic [31:0] m_pc;
    logic        m_req, m_out, m_stale;
    logic [63:0] skid_q[$];
    logic        ov;
    logic [31:0] opc, oinstr;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'd0; m_req = 1'b0; m_out = 1'b0; m_stale = 1'b0;
        skid_q.delete();
        ov = 1'b0; opc = 32'd0; oinstr = NOP;
    endtask

    task automatic model_step();
        logic        redir, resp, granted, got;
        logic [31:0] tgt;
        logic [63:0] e;
        redir   = ID_Jump || EX_PC_Branch;
        tgt     = (EX_PC_Branch ? EX_PC_Branch_dest : ID_PC_dest) & 32'hFFFF_FFFC;
        resp    = m_out && instr_valid;
        granted = m_req && imem_gnt;
        got     = resp && !m_stale && !redir;
        if (redir) begin
            skid_q.delete(); ov = 1'b0; oinstr = NOP;
        end else if (PC_Stall) begin
            if (got) skid_q.push_back({m_pc, instr});
        end else if (skid_q.size() > 0) begin
            e = skid_q.pop_front();
            ov = 1'b1; opc = e[63:32]; oinstr = e[31:0];
            if (got) skid_q.push_back({m_pc, instr});
        end else if (got) begin
            ov = 1'b1; opc = m_pc; oinstr = instr;
        end else begin
            ov = 1'b0; oinstr = NOP;
        end
        if (got) m_pc = m_pc + 32'd4;
        if (redir) m_pc = tgt;
        if (resp) begin
            m_out = 1'b0; m_stale = 1'b0;
        end else if (granted) begin
            m_out = 1'b1; m_stale = redir;
        end else if (m_out && redir) begin
            m_stale = 1'b1;
        end
        m_req = !m_out && (skid_q.size() == 0);
    endtask

    // Called at a falling edge; compares, drives, advances one rising edge, returns at the next falling edge.
    task automatic cycle();
        logic        s_req;
        logic [31:0] s_addr;
        check_val("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        check_val("imem_addr", imem_addr, m_pc);
        check_val("IF_Valid", {31'd0, IF_Valid}, {31'd0, ov});
        check_val("IF_PC", IF_PC, opc);
        check_val("IF_Instruction", IF_Instruction, oinstr);
        s_req  = imem_req;
        s_addr = imem_addr;
        imem_gnt    = s_req && !mem_busy && ($urandom_range(99) < p_gnt);
        instr_valid = 1'b0;
        instr       = $urandom;
        if (mem_busy && mem_dly == 0) begin
            instr_valid = 1'b1;
            instr       = mem_addr ^ 32'h0000_00A5;
        end else if (!mem_busy && ($urandom_range(99) < p_stray)) begin
            instr_valid = 1'b1;
        end
        PC_Stall          = f_stall || ($urandom_range(99) < p_stall);
        ID_Jump           = f_jump || ($urandom_range(99) < p_redir);
        ID_PC_dest        = f_jump ? f_jdest : $urandom;
        EX_PC_Branch      = f_br || ($urandom_range(99) < p_redir);
        EX_PC_Branch_dest = f_br ? f_bdest : $urandom;
        @(posedge Clk);
        model_step();
        if (s_req && imem_gnt) begin
            gaddr_q.push_back(s_addr);
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_dly  = min_dly + $urandom_range(max_dly - min_dly);
        end else if (mem_busy) begin
            if (instr_valid) mem_busy = 1'b0;
            else mem_dly = mem_dly - 1;
        end
        @(negedge Clk);
    endtask

    // Called at a falling edge; asserts reset, checks immediate reset values, releases at the next falling edge.
    task automatic do_reset();
        Reset_n = 1'b0;
        imem_gnt = 1'b0; instr_valid = 1'b0; PC_Stall = 1'b0; ID_Jump = 1'b0; EX_PC_Branch = 1'b0;
        #1;
        check_val("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_imem_addr", imem_addr, 32'd0);
        check_val("rst_IF_Valid", {31'd0, IF_Valid}, 32'd0);
        check_val("rst_IF_PC", IF_PC, 32'd0);
        check_val("rst_IF_Instruction", IF_Instruction, NOP);
        m_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        logic found;
        m_reset();
        @(negedge Clk);
        do_reset();

        // scripted walk: zero-wait start, grant hold-off, stall with skid, jump in WAIT, jump+branch
        for (int k = 0; k < 24; k++) begin
            p_gnt   = ((k >= 3 && k <= 6) || k == 22) ? 0 : 100;
            f_stall = (k >= 10 && k <= 14);
            f_jump  = (k == 17 || k == 22);
            f_jdest = 32'h0000_0100;
            f_br    = (k == 22);
            f_bdest = 32'h0000_0200;
            if (k == 16) begin
                min_dly = 1; max_dly = 1;
            end
            case (k)
                1: begin
                    check_val("start_req", {31'd0, imem_req}, 32'd1);
                    check_val("start_addr0", imem_addr, 32'd0);
                end
                2: check_val("valid_not_before_3", {31'd0, IF_Valid}, 32'd0);
                3: begin
                    check_val("first_valid", {31'd0, IF_Valid}, 32'd1);
                    check_val("first_pc", IF_PC, 32'd0);
                    check_val("first_instr", IF_Instruction, 32'h0000_00A5);
                    check_val("addr4", imem_addr, 32'd4);
                end
                7: begin
                    check_val("nogrant_req", {31'd0, imem_req}, 32'd1);
                    check_val("nogrant_addr", imem_addr, 32'd4);
                    check_val("nogrant_pc", IF_PC, 32'd0);
                end
                9: begin
                    check_val("addr8", imem_addr, 32'd8);
                    check_val("pc4", IF_PC, 32'd4);
                end
                15: begin
                    check_val("stall_frozen_pc", IF_PC, 32'd4);
                    check_val("stall_valid", {31'd0, IF_Valid}, 32'd0);
                    check_val("stall_no_req", {31'd0, imem_req}, 32'd0);
                end
                16: begin
                    check_val("skid_pc8", IF_PC, 32'd8);
                    check_val("skid_valid", {31'd0, IF_Valid}, 32'd1);
                    check_val("after_skid_req", {31'd0, imem_req}, 32'd1);
                    check_val("after_skid_addr12", imem_addr, 32'd12);
                end
                19: begin
                    check_val("jump_addr", imem_addr, 32'h0000_0100);
                    check_val("jump_req", {31'd0, imem_req}, 32'd1);
                    check_val("jump_valid_low", {31'd0, IF_Valid}, 32'd0);
                end
                22: begin
                    check_val("jump_pc", IF_PC, 32'h0000_0100);
                    check_val("jump_inst_valid", {31'd0, IF_Valid}, 32'd1);
                    check_val("jump_instr", IF_Instruction, 32'h0000_01A5);
                end
                23: begin
                    check_val("branch_prio_addr", imem_addr, 32'h0000_0200);
                    check_val("branch_prio_req", {31'd0, imem_req}, 32'd1);
                end
                default: ;
            endcase
            cycle();
        end

        // reset while waiting; the stale response lands in the IDLE cycle
        f_stall = 1'b0; f_jump = 1'b0; f_br = 1'b0; p_gnt = 100;
        min_dly = 0; max_dly = 0;
        mem_dly = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                check_val("post_rst_pc", IF_PC, 32'd0);
                check_val("post_rst_valid", {31'd0, IF_Valid}, 32'd1);
                check_val("post_rst_instr", IF_Instruction, 32'h0000_00A5);
            end
            cycle();
        end

        // PC wrap from the top word of the address space
        gaddr_q.delete();
        f_jump = 1'b1; f_jdest = 32'hFFFF_FFFF;
        cycle();
        f_jump = 1'b0;
        for (int k = 0; k < 12; k++) cycle();
        found = 1'b0;
        for (int i = 0; i + 1 < gaddr_q.size(); i++) begin
            if (!found && gaddr_q[i] == 32'hFFFF_FFFC) begin
                found = 1'b1;
                check_val("wrap_next_addr", gaddr_q[i+1], 32'd0);
            end
        end
        check_val("wrap_top_fetched", {31'd0, found}, 32'd1);

        // randomized traffic
        p_gnt = 60; min_dly = 0; max_dly = 3; p_stall = 25; p_redir = 6; p_stray = 5;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(399) == 0) do_reset();
            else cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
